// File: rtl/ldl_shift_ring_unrot_seq_pkg.sv
// Shared types and constants for the iterative ring un-rotator.
//   state_e   : controller states (IDLE / SHIFT / DONE)
//   DIR_LEFT  : forward rotator rotated left  (encoding 0)
//   DIR_RIGHT : forward rotator rotated right (encoding 1)
package ldl_shift_ring_unrot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Direction that undoes a rotation made in direction d.
  function automatic logic inv_dir(input logic d);
    return (d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/ldl_shift_ring_unrot_seq_if.sv
// Request/response bundle of the ring un-rotator.
//   in_valid/in_ready : request handshake, carries dir, step, x
//   out_valid/out_ready : response handshake, carries y
//   busy : controller is outside IDLE
// master = requester/consumer side, slave = the un-rotator.
interface ldl_shift_ring_unrot_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic             dir;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  modport master (
    output in_valid, dir, step, x, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, dir, step, x, out_ready,
    output in_ready, out_valid, y, busy
  );

endinterface

// File: rtl/ldl_shift_ring_unrot_seq_step.sv
// Combinational one-position ring rotate of a WIDTH-bit word.
//   data_i  : word to rotate
//   dir_i   : DIR_LEFT rotates towards the MSB, DIR_RIGHT towards the LSB
//   rot_o_c : rotated word (combinational)
module ldl_shift_ring_unrot_seq_step
  import ldl_shift_ring_unrot_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] rot_o_c
);

  always_comb begin
    rot_o_c = data_i;
    if (dir_i == DIR_LEFT) begin
      rot_o_c = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
    end else begin
      rot_o_c = {data_i[0], data_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ldl_shift_ring_unrot_seq.sv
// Iterative ring un-rotator: restores a word rotated by a forward rotator
// by rotating it back one position per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of ldl_shift_ring_unrot_seq_if
//          (in_valid/in_ready/dir/step/x in, out_valid/out_ready/y out, busy)
// All outputs come straight from registers.
module ldl_shift_ring_unrot_seq
  import ldl_shift_ring_unrot_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  ldl_shift_ring_unrot_seq_if.slave   bus
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] rot_c;

  // One-position rotate in the direction opposite to the captured one.
  ldl_shift_ring_unrot_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i  (data_q),
    .dir_i   (inv_dir(dir_q)),
    .rot_o_c (rot_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.x;
          cnt_d   = bus.step;
          dir_d   = bus.dir;
          state_d = (bus.step == SW'(0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = rot_c;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered handshake outputs; flags follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_LEFT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.y         = data_q;

endmodule

// File: tb/tb_ldl_shift_ring_unrot_seq.sv
// Self-checking bench for ldl_shift_ring_unrot_seq at WIDTH = 8.
module tb_ldl_shift_ring_unrot_seq;

  logic clk;
  logic rst;

  ldl_shift_ring_unrot_seq_if #(.WIDTH(8)) bus ();

  ldl_shift_ring_unrot_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [2:0] step;
    logic       dir;
    logic [7:0] exp_y;
    int         hold;
    bit         noise;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] sb_q [$];
  int         n_checks;
  int         n_errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: undo a rotation of s positions made in direction d.
  function automatic logic [7:0] model(input logic [7:0] x, input logic [2:0] s, input logic d);
    logic [15:0] w;
    logic [15:0] r;
    w = {x, x};
    if (d == 1'b0) begin
      r = w >> s;
      return r[7:0];
    end else begin
      r = w << s;
      return r[15:8];
    end
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = 8'h00;
    bus.step      = 3'd0;
    bus.dir       = 1'b0;
  endtask

  // One full request: accept, latency count, optional back-pressure, handshake.
  task automatic do_req(input logic [7:0] x, input logic [2:0] s, input logic d,
                        input logic [7:0] exp_y, input int hold, input bit noise);
    int         lat;
    logic [7:0] y0;
    logic [7:0] exp_pop;
    @(negedge clk);
    check("in_ready_before_req", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.x        = x;
    bus.step     = s;
    bus.dir      = d;
    sb_q.push_back(exp_y);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    if (!noise) bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      if (noise) begin
        bus.x    = 8'($urandom);
        bus.step = 3'($urandom);
        bus.dir  = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("out_valid_latency", 32'(lat), 32'(s));
    check("busy_in_done", 32'(bus.busy), 32'd1);
    y0 = bus.y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {bus.y, 7'd0, bus.out_valid, 7'd0, bus.in_ready, 8'd0},
            {y0, 7'd0, 1'b1, 7'd0, 1'b0, 8'd0});
    end
    bus.out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_pop = sb_q.pop_front();
      check("y_result", 32'(bus.y), 32'(exp_pop));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_handshake", {31'd0, bus.out_valid} | {30'd0, bus.busy, 1'b0} |
          {29'd0, bus.in_ready, 2'b0}, 32'd4);
  endtask

  initial begin
    int seen;
    int lat;
    n_checks = 0;
    n_errs   = 0;

    vecs[0] = '{x: 8'h2D, step: 3'd3, dir: 1'b0, exp_y: 8'hA5, hold: 0, noise: 1'b0};
    vecs[1] = '{x: 8'hD2, step: 3'd1, dir: 1'b1, exp_y: 8'hA5, hold: 0, noise: 1'b0};
    vecs[2] = '{x: 8'h3C, step: 3'd0, dir: 1'b0, exp_y: 8'h3C, hold: 0, noise: 1'b0};
    vecs[3] = '{x: 8'h01, step: 3'd7, dir: 1'b0, exp_y: 8'h02, hold: 4, noise: 1'b0};
    vecs[4] = '{x: 8'h80, step: 3'd7, dir: 1'b1, exp_y: 8'h40, hold: 1, noise: 1'b0};
    vecs[5] = '{x: 8'hF0, step: 3'd4, dir: 1'b0, exp_y: 8'h0F, hold: 0, noise: 1'b0};
    vecs[6] = '{x: 8'h96, step: 3'd2, dir: 1'b1, exp_y: 8'h5A, hold: 0, noise: 1'b1};
    vecs[7] = '{x: 8'h2D, step: 3'd5, dir: 1'b0, exp_y: 8'h69, hold: 2, noise: 1'b1};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", {bus.in_ready, bus.out_valid, bus.busy, bus.y},
          {1'b1, 1'b0, 1'b0, 8'h00});

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].x, vecs[i].step, vecs[i].dir, vecs[i].exp_y, vecs[i].hold, vecs[i].noise);
    end

    // Random requests against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rx;
      logic [2:0] rs;
      logic       rd;
      rx = 8'($urandom);
      rs = 3'($urandom);
      rd = 1'($urandom);
      do_req(rx, rs, rd, model(rx, rs, rd), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Reset two cycles into a step=5 request, with in_valid high at the reset edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 8'hA7;
    bus.step     = 3'd5;
    bus.dir      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("busy_mid_shift", 32'(bus.busy), 32'd1);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("reset_mid_shift", {bus.in_ready, bus.out_valid, bus.busy, bus.y},
          {1'b1, 1'b0, 1'b0, 8'h00});
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("no_valid_after_reset", 32'(seen), 32'd0);
    do_req(8'h2D, 3'd3, 1'b0, 8'hA5, 0, 1'b0);

    // Reset while in DONE, with out_ready raised at the same edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 8'hC3;
    bus.step     = 3'd2;
    bus.dir      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("done_reached_before_reset", 32'(lat), 32'd2);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    check("reset_in_done", {bus.in_ready, bus.out_valid, bus.busy, bus.y},
          {1'b1, 1'b0, 1'b0, 8'h00});
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("no_valid_after_done_reset", 32'(seen), 32'd0);
    do_req(8'hD2, 3'd1, 1'b1, 8'hA5, 0, 1'b0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ldl_shift_ring_unrot_seq.md
LDL_SHIFT_RING_UNROT_SEQ -- requirements
Module: LDL_shift_ring_unrot_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal values are powers of two, 2 or more.
REQ-002 SHALL have one clock and a synchronous active-high reset.
REQ-003 SHALL have port `clk`  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port `rst`  input  1  synchronous active-high reset.
REQ-005 SHALL have port `in_valid`  input  1  request is presented.
REQ-006 SHALL have port `in_ready`  output  1  block can accept a request.
REQ-007 SHALL have port `dir`  input  1  direction used by the forward rotator: 0 = it rotated left, 1 = it rotated right.
REQ-008 SHALL have port `step`  input  $clog2(WIDTH)  rotation amount the forward rotator applied.
REQ-009 SHALL have port `x`  input  WIDTH  rotated data word.
REQ-010 SHALL have port `out_valid`  output  1  restored word is available.
REQ-011 SHALL have port `out_ready`  input  1  consumer takes the word.
REQ-012 SHALL have port `y`  output  WIDTH  restored data word.
REQ-013 SHALL have port `busy`  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL undo a forward ring rotation: y = x rotated by step in the direction opposite to dir (dir=0 means rotate right; dir=1 means rotate left).
REQ-015 SHALL rotate one bit position per clock, iteratively; no barrel shifter.
REQ-016 SHALL use three FSM states: IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; drive out_valid = 1 only in DONE; no combinational path from any input to any output.
REQ-018 SHALL on accept (IDLE and in_valid = 1): load data register with x, count with step, direction register with dir; go to DONE if step = 0, else go to SHIFT.
REQ-019 SHALL in SHIFT, on each edge: rotate data register by 1 position in the inverse direction and decrement count; go to DONE on the edge where count goes from 1 to 0.
REQ-020 SHALL assert out_valid exactly after edge k+step, where k is the accept edge (step = 0 gives 1 cycle).
REQ-021 SHALL in DONE: hold y stable while out_ready = 0; on out_ready = 1 return to IDLE.
REQ-022 SHALL ignore in_valid, x, step and dir outside IDLE; captured values are unaffected.
REQ-023 SHALL make a new request acceptable no earlier than the cycle after the DONE handshake (no overlap).
REQ-024 SHALL for step = WIDTH-1, complete in WIDTH-1 shift cycles; there is no modulo special case.
REQ-025 SHALL drive y from the data register at all times; y value is meaningful only while out_valid = 1.

Reset
REQ-026 SHALL on rst = 1 at an edge: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, y = 0, count = 0.
REQ-027 SHALL on reset mid-SHIFT or in DONE: abandon the operation; no out_valid pulse follows.
REQ-028 SHALL give rst priority over any simultaneous in_valid or out_ready.

Structure
REQ-029 SHALL take the state enum (IDLE/SHIFT/DONE) and the dir encoding constants (DIR_LEFT = 0, DIR_RIGHT = 1) from shared package LDL_pkg.
REQ-030 SHALL instantiate one sub-module, LDL_shift_ring_step: combinational 1-position rotate of WIDTH bits, with a direction input.
REQ-031 SHALL keep the FSM, counter and registers in this module.

Verification (WIDTH = 8)
REQ-032 SHALL cover: x=8'h2D, step=3, dir=0 -> y=8'hA5; out_valid rises 3 cycles after accept.
REQ-033 SHALL cover: x=8'hD2, step=1, dir=1 -> y=8'hA5 after 1 cycle.
REQ-034 SHALL cover: x=8'h3C, step=0 -> y=8'h3C, out_valid 1 cycle after accept, busy high only during that cycle.
REQ-035 SHALL cover: x=8'h01, step=7, dir=0 -> y=8'h02 at edge k+7; with out_ready held 0 for 4 cycles, y and out_valid stay stable and in_ready stays 0.
REQ-036 SHALL cover: rst pulsed 2 cycles into a step=5 request -> IDLE with in_ready=1 and y=0; no out_valid pulse; next request completes normally.
REQ-037 SHALL cover: in_valid held high with changing x during SHIFT -> result matches the originally captured word only.
